// File: rtl/fir_filter_pkg.sv
// fir_filter_pkg: shared state encodings and widths for the FIR filter datapath
package fir_filter_pkg;
  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;
  localparam int ERR_W = 8;
endpackage

// File: rtl/deserializer_sat_counter.sv
// sat_counter: incrementer that sticks at all-ones, async active-high reset
module sat_counter
  import fir_filter_pkg::*;
#(
  parameter int W = ERR_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] ov_count
);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) ov_count <= '0;
    else if (i_inc && ov_count != '1) ov_count <= ov_count + 1'b1;
endmodule

// File: rtl/deserializer.sv
// deserializer: LSB-first sync-framed serial-to-parallel receiver; DESERIALIZER_SYNC_CHECK_EN adds misaligned-sync reporting
module deserializer
  import fir_filter_pkg::*;
#(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_sync,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  output logic              o_sync_err,
  output logic [ERR_W-1:0]  ov_err_count
);
  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LENGTH-1:0] sr, sr_n, dout_n, shifted;
  logic valid_n;
  assign shifted = {i_din, sr[LENGTH-1:1]};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    dout_n = ov_dout;
    valid_n = 1'b0;
    if (i_en) begin
      if (i_sync) begin
        sr_n = shifted;
        cnt_n = CW'(1);
        state_n = RECV;
      end else if (state == RECV) begin
        sr_n = shifted;
        cnt_n = cnt == LAST ? '0 : cnt + 1'b1;
        state_n = cnt == LAST ? IDLE : RECV;
        dout_n = cnt == LAST ? shifted : ov_dout;
        valid_n = cnt == LAST;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      ov_dout <= '0;
      o_dout_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      ov_dout <= dout_n;
      o_dout_valid <= valid_n;
    end
`ifdef DESERIALIZER_SYNC_CHECK_EN
  logic mis;
  assign mis = i_en && i_sync && state == RECV;
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (mis),
    .ov_count(ov_err_count)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_sync_err <= 1'b0;
    else if (mis) o_sync_err <= 1'b1;
`else
  assign o_sync_err = 1'b0;
  assign ov_err_count = '0;
`endif
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: randomized and directed checks of deserializer against a queue-based frame model
module tb_deserializer;
  localparam int L = 24;
`ifdef DESERIALIZER_SYNC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic i_clk = 1'b0;
  logic i_rst = 1'b1, i_en = 1'b0, i_din = 1'b0, i_sync = 1'b0;
  logic [L-1:0] ov_dout;
  logic o_dout_valid, o_sync_err;
  logic [7:0] ov_err_count;
  int errors = 0, checks = 0, cyc = 0;
  bit bq[$];
  bit inframe;
  logic [L-1:0] e_dout;
  bit e_valid, e_err;
  int e_cnt;

  always #5 i_clk = ~i_clk;

  deserializer #(.LENGTH(L)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_din(i_din), .i_sync(i_sync),
    .ov_dout(ov_dout), .o_dout_valid(o_dout_valid), .o_sync_err(o_sync_err),
    .ov_err_count(ov_err_count)
  );

  task automatic model_reset();
    bq.delete();
    inframe = 0;
    e_dout = '0;
    e_valid = 0;
    e_err = 0;
    e_cnt = 0;
  endtask

  // a frame is the sync bit plus the following L-1 enabled bits; a sync inside a frame restarts it
  task automatic step(input bit en, input bit d, input bit s);
    @(negedge i_clk);
    i_en = en; i_din = d; i_sync = s;
    @(posedge i_clk);
    cyc++;
    e_valid = 0;
    if (en) begin
      if (s) begin
        if (inframe && CHK) begin
          e_err = 1;
          if (e_cnt < 255) e_cnt++;
        end
        bq.delete();
        bq.push_back(d);
        inframe = 1;
      end else if (inframe) begin
        bq.push_back(d);
        if (bq.size() == L) begin
          for (int i = 0; i < L; i++) e_dout[i] = bq[i];
          e_valid = 1;
          inframe = 0;
          bq.delete();
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1; i_en = 0; i_sync = 0; i_din = 0;
    @(negedge i_clk);
    i_rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    #23;
    checks += 4;
    if (ov_dout !== '0) begin errors++; $display("FAIL reset_dout got=%h exp=0", ov_dout); end
    if (o_dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_dout_valid); end
    if (o_sync_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_sync_err); end
    if (ov_err_count !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", ov_err_count); end
    @(negedge i_clk);
    i_rst = 0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 30; i++) begin
      step(1, 1'($urandom), 0);
      checks++;
      if (o_dout_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", i, o_dout_valid); end
    end
    checks++;
    if (ov_dout !== '0) begin errors++; $display("FAIL idle_dout got=%h exp=0", ov_dout); end
  endtask

  task automatic test_single();
    logic [L-1:0] w = 24'hA5C3F0;
    for (int i = 0; i < L; i++) begin
      step(1, w[i], i == 0);
      checks++;
      if (o_dout_valid !== e_valid) begin errors++; $display("FAIL single_valid bit=%0d got=%b exp=%b", i, o_dout_valid, e_valid); end
    end
    checks += 2;
    if (ov_dout !== w) begin errors++; $display("FAIL single_dout got=%h exp=%h", ov_dout, w); end
    if (o_dout_valid !== 1'b1) begin errors++; $display("FAIL single_pulse got=%b exp=1", o_dout_valid); end
    step(1, 0, 0);
    checks++;
    if (o_dout_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_end got=%b exp=0", o_dout_valid); end
  endtask

  task automatic test_gaps();
    logic [L-1:0] w = 24'hA5C3F0;
    int pulses = 0;
    do_reset();
    for (int i = 0; i < L; i++) begin
      step(1, w[i], i == 0);
      if (o_dout_valid === 1'b1) pulses++;
      if (i == 5 || i == 17)
        for (int g = 0; g < 3; g++) begin
          step(0, 1'($urandom), 1'($urandom));
          checks++;
          if (o_dout_valid !== 1'b0) begin errors++; $display("FAIL gap_valid bit=%0d got=%b exp=0", i, o_dout_valid); end
        end
    end
    for (int i = 0; i < 3; i++) begin
      step(i == 0 ? 1'b0 : 1'b1, 0, 0);
      if (o_dout_valid === 1'b1) pulses++;
    end
    checks += 2;
    if (ov_dout !== w) begin errors++; $display("FAIL gap_dout got=%h exp=%h", ov_dout, w); end
    if (pulses != 1) begin errors++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] w [2] = '{24'h000001, 24'hFFFFFE};
    int pc [2];
    logic [L-1:0] pd [2];
    int n = 0;
    logic [L-1:0] cur;
    for (int i = 0; i < 2 * L + 1; i++) begin
      cur = w[(i / L) % 2];
      step(1, i < 2 * L ? cur[i % L] : 1'b0, i % L == 0 && i < 2 * L);
      if (o_dout_valid === 1'b1) begin
        if (n < 2) begin pc[n] = cyc; pd[n] = ov_dout; end
        n++;
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", n); end
    else begin
      checks += 3;
      if (pc[1] - pc[0] != L) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", pc[1] - pc[0], L); end
      if (pd[0] !== w[0]) begin errors++; $display("FAIL b2b_word0 got=%h exp=%h", pd[0], w[0]); end
      if (pd[1] !== w[1]) begin errors++; $display("FAIL b2b_word1 got=%h exp=%h", pd[1], w[1]); end
    end
  endtask

  task automatic test_misaligned();
    logic [L-1:0] w = 24'h123456;
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1'($urandom), i == 0);
    for (int i = 0; i < L; i++) begin
      step(1, w[i], i == 0);
      checks++;
      if (o_dout_valid !== e_valid) begin errors++; $display("FAIL mis_valid bit=%0d got=%b exp=%b", i, o_dout_valid, e_valid); end
      if (i == 13) begin
        checks++;
        if (ov_dout !== '0) begin errors++; $display("FAIL mis_old_boundary got=%h exp=0", ov_dout); end
      end
    end
    checks += 3;
    if (ov_dout !== w) begin errors++; $display("FAIL mis_dout got=%h exp=%h", ov_dout, w); end
    if (o_sync_err !== CHK) begin errors++; $display("FAIL mis_err got=%b exp=%b", o_sync_err, CHK); end
    if (ov_err_count !== (CHK ? 8'd1 : 8'd0)) begin errors++; $display("FAIL mis_cnt got=%0d exp=%0d", ov_err_count, CHK ? 1 : 0); end
  endtask

  task automatic test_reset_midframe();
    logic [L-1:0] w = L'($urandom);
    for (int i = 0; i < 12; i++) step(1, 1'($urandom), i == 0);
    @(negedge i_clk);
    i_rst = 1;
    #1;
    checks += 4;
    if (ov_dout !== '0) begin errors++; $display("FAIL rstmid_dout got=%h exp=0", ov_dout); end
    if (o_dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", o_dout_valid); end
    if (o_sync_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", o_sync_err); end
    if (ov_err_count !== 8'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", ov_err_count); end
    @(negedge i_clk);
    i_rst = 0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 1'($urandom), 0);
      checks++;
      if (o_dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale got=%b exp=0", o_dout_valid); end
    end
    for (int i = 0; i < L; i++) step(1, w[i], i == 0);
    checks += 2;
    if (o_dout_valid !== 1'b1) begin errors++; $display("FAIL rstmid_next_valid got=%b exp=1", o_dout_valid); end
    if (ov_dout !== w) begin errors++; $display("FAIL rstmid_next_dout got=%h exp=%h", ov_dout, w); end
  endtask

  task automatic test_random();
    bit s;
    for (int i = 0; i < 3000; i++) begin
      s = inframe ? ($urandom_range(39) == 0) : ($urandom_range(2) == 0);
      step($urandom_range(7) != 0, 1'($urandom), s);
      checks += 4;
      if (o_dout_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, o_dout_valid, e_valid); end
      if (ov_dout !== e_dout) begin errors++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", i, ov_dout, e_dout); end
      if (o_sync_err !== e_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, o_sync_err, e_err); end
      if (ov_err_count !== 8'(e_cnt)) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, ov_err_count, e_cnt); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k <= 300; k++) begin
      step(1, 1'($urandom), 1);
      for (int j = 0; j < k % 23; j++) step(1, 1'($urandom), 0);
      checks++;
      if (ov_err_count !== 8'(e_cnt)) begin errors++; $display("FAIL sat_step k=%0d got=%0d exp=%0d", k, ov_err_count, e_cnt); end
    end
    checks += 3;
    if (ov_err_count !== (CHK ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", ov_err_count, CHK ? 255 : 0); end
    if (o_sync_err !== CHK) begin errors++; $display("FAIL sat_err got=%b exp=%b", o_sync_err, CHK); end
    if (ov_dout !== '0) begin errors++; $display("FAIL sat_dout got=%h exp=0", ov_dout); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_gaps();
    test_back_to_back();
    test_misaligned();
    test_reset_midframe();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
